// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU sequencer.
//   state_t   - sequencer FSM states
//   kind_t    - decoded instruction class
//   OPC_*     - major opcode values in instr[15:13]
//   ALU_*     - 2-bit ALUop codes driven to the ALU
//   VSEL_*    - write-back mux select codes
package alu_seq_pkg;

    localparam int INSTR_W  = 16;
    localparam int REGSEL_W = 3;

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_DEC   = 3'd1,
        S_GETA  = 3'd2,
        S_GETB  = 3'd3,
        S_OPER  = 3'd4,
        S_WRITE = 3'd5,
        S_WIMM  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        K_ILL  = 3'd0,
        K_MOVI = 3'd1,
        K_MOVR = 3'd2,
        K_ADD  = 3'd3,
        K_CMP  = 3'd4,
        K_AND  = 3'd5,
        K_MVN  = 3'd6
    } kind_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: purely combinational decode of the latched instruction.
// Ports:
//   instr  in  16  latched instruction
//   kind   out     decoded instruction class (K_ILL for illegal encodings)
//   op     out  2  instr[12:11]
//   rn     out  3  instr[10:8]
//   rd     out  3  instr[7:5]
//   sh     out  2  instr[4:3]
//   rm     out  3  instr[2:0]
//   sximm8 out 16  sign-extended instr[7:0]
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [15:0] instr,
    output kind_t       kind,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [15:0] sximm8
);

    logic [2:0] opcode;

    assign opcode = instr[15:13];
    assign op     = instr[12:11];
    assign rn     = instr[10:8];
    assign rd     = instr[7:5];
    assign sh     = instr[4:3];
    assign rm     = instr[2:0];
    assign sximm8 = sext8(instr[7:0]);

    always_comb begin
        kind = K_ILL;
        case (opcode)
            OPC_MOV: begin
                if (op == 2'b10)
                    kind = K_MOVI;
                else if (op == 2'b00)
                    kind = K_MOVR;
            end
            OPC_ALU: begin
                case (op)
                    2'b00:   kind = K_ADD;
                    2'b01:   kind = K_CMP;
                    2'b10:   kind = K_AND;
                    default: kind = K_MVN;
                endcase
            end
            default: kind = K_ILL;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control FSM for the 16-bit RISC datapath.
// Accepts one instruction per start/ready handshake, then sequences the
// register file, A/B/C/status loads and mux selects for that instruction.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   instr, start, ready   instruction handshake (latched on start & ready)
//   done, err             last-cycle pulse / illegal-encoding pulse
//   readnum, writenum     register-file selects
//   write                 register-file write enable
//   loada/loadb/loadc/loads  datapath register loads
//   asel, bsel, vsel      datapath mux selects (bsel held 0)
//   shift, alu_op         shifter control and ALUop
//   sximm8                sign-extended immediate from the latched instr
// Optional build macro ALU_SEQ_PERF_EN adds instr_count[15:0] (wrapping
// count of done pulses) and err_count[7:0] (saturating count of err pulses).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_WAIT  | idle, ready = 1, latch instr on start
// S_DEC   | decode; err pulse and return here if illegal
// S_GETA  | read Rn into A
// S_GETB  | read Rm into B
// S_OPER  | run shifter/ALU into C (CMP: load status, finish)
// S_WRITE | write C back to Rd, finish
// S_WIMM  | write sximm8 to Rn, finish
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int INSTR_W  = alu_seq_pkg::INSTR_W,
    parameter int REGSEL_W = alu_seq_pkg::REGSEL_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                start,
    output logic                ready,
    output logic                done,
    output logic                err,
    output logic [REGSEL_W-1:0] readnum,
    output logic [REGSEL_W-1:0] writenum,
    output logic                write,
    output logic                loada,
    output logic                loadb,
    output logic                loadc,
    output logic                loads,
    output logic                asel,
    output logic                bsel,
    output logic [1:0]          vsel,
    output logic [1:0]          shift,
    output logic [1:0]          alu_op,
    output logic [15:0]         sximm8
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]         instr_count,
    output logic [7:0]          err_count
`endif
);

    state_t             state;
    state_t             state_nxt;
    logic [INSTR_W-1:0] instr_q;

    kind_t      kind;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;

    alu_seq_decode u_decode (
        .instr  (instr_q),
        .kind   (kind),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (sximm8)
    );

    // Instruction latch: only the accepting edge updates it, so the
    // source may change instr freely while an instruction is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            instr_q <= '0;
        else if (state == S_WAIT && start)
            instr_q <= instr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_WAIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT: begin
                if (start)
                    state_nxt = S_DEC;
            end
            S_DEC: begin
                case (kind)
                    K_MOVI:                state_nxt = S_WIMM;
                    K_MOVR, K_MVN:         state_nxt = S_GETB;
                    K_ADD, K_CMP, K_AND:   state_nxt = S_GETA;
                    default:               state_nxt = S_WAIT;
                endcase
            end
            S_GETA:  state_nxt = S_GETB;
            S_GETB:  state_nxt = S_OPER;
            S_OPER:  state_nxt = (kind == K_CMP) ? S_WAIT : S_WRITE;
            S_WRITE: state_nxt = S_WAIT;
            S_WIMM:  state_nxt = S_WAIT;
            default: state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        vsel     = VSEL_C;
        shift    = 2'b00;
        alu_op   = ALU_ADD;
        case (state)
            S_WAIT: ready = 1'b1;
            S_DEC:  err   = (kind == K_ILL);
            S_GETA: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GETB: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_OPER: begin
                shift = sh;
                if (kind == K_CMP) begin
                    // CMP only updates status; C and the register file stay put.
                    alu_op = ALU_SUB;
                    loads  = 1'b1;
                    done   = 1'b1;
                end else if (kind == K_MOVR) begin
                    // A forced to 0 so ADD passes the shifted B straight through.
                    alu_op = ALU_ADD;
                    asel   = 1'b1;
                    loadc  = 1'b1;
                end else begin
                    alu_op = op;
                    loadc  = 1'b1;
                end
            end
            S_WRITE: begin
                writenum = rd;
                vsel     = VSEL_C;
                write    = 1'b1;
                done     = 1'b1;
            end
            S_WIMM: begin
                writenum = rn;
                vsel     = VSEL_IMM8;
                write    = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bsel = 1'b0;

`ifdef ALU_SEQ_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_count <= '0;
            err_count   <= '0;
        end else begin
            if (done)
                instr_count <= instr_count + 16'd1;
            if (err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit RISC datapath: register file, A/B operand registers, shifter, ALU, C result register and status register.
- Accepts one 16-bit instruction per handshake and decodes it.
- Drives the register-file read/write selects, the load enables and the mux selects, and the 2-bit ALUop to the ALU (00 add, 01 sub, 10 and, 11 not B).
- Sits between the instruction source and the datapath top.

Parameters:
- INSTR_W, 16, instruction width; fixed field layout below.
- REGSEL_W, 3, register-number width (8 registers).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- instr  in  16  instruction; sampled when start & ready
- start  in  1  instruction valid
- ready  out  1  high only in S_WAIT
- done  out  1  one-cycle pulse in the last cycle of an instruction
- err  out  1  one-cycle pulse on an illegal encoding
- readnum  out  3  register-file read select
- writenum  out  3  register-file write select
- write  out  1  register-file write enable
- loada  out  1  A register load
- loadb  out  1  B register load
- loadc  out  1  C register load
- loads  out  1  status register load
- asel  out  1  1 = A input forced to 0
- bsel  out  1  1 = B input takes sximm5 (unused here, held 0)
- vsel  out  2  write-back mux: 00 = C, 10 = sximm8
- shift  out  2  shifter control, taken from instr[4:3]
- alu_op  out  2  ALUop to the ALU
- sximm8  out  16  sign-extended instr[7:0]

Behaviour:
- Instruction fields, from the latched copy:
  - opcode = [15:13], op = [12:11], Rn = [10:8], Rd = [7:5], sh = [4:3], Rm = [2:0], imm8 = [7:0]
- Legal encodings:
  - 110/10: MOV Rn,#imm8
  - 110/00: MOV Rd,Rm{sh}
  - 101/00: ADD
  - 101/01: CMP
  - 101/10: AND
  - 101/11: MVN
  - Any other encoding is illegal.
- Acceptance: instr is latched on the edge where start = 1 in S_WAIT. start is ignored in every other state. No queueing.
- States and outputs:
  - S_WAIT: ready = 1.
  - S_DEC: one cycle. Branches on the decode:
    - MOV imm -> S_WIMM
    - MOV reg -> S_GETB
    - MVN -> S_GETB
    - ADD, CMP, AND -> S_GETA
    - illegal -> S_WAIT, err pulses in S_DEC
  - S_GETA: readnum = Rn, loada = 1.
  - S_GETB: readnum = Rm, loadb = 1.
  - S_OPER: loadc = 1, alu_op = op, shift = sh.
    - MOV reg: asel = 1, alu_op = 00.
    - CMP: loads = 1, loadc = 0, done = 1, next state S_WAIT.
  - S_WRITE: writenum = Rd, write = 1, vsel = 00, done = 1, next state S_WAIT.
  - S_WIMM: writenum = Rn, vsel = 10, write = 1, done = 1, next state S_WAIT.
- Latency, counted from the accepting edge to the done cycle:
  - MOV imm: 2 cycles
  - MOV reg, MVN: 4 cycles
  - ADD, AND: 5 cycles
  - CMP: 4 cycles
- Output defaults: every control output is 0 outside the state that asserts it. Control outputs are decoded combinationally from state and the latched instruction.
- Reset (asynchronous, reset_n = 0):
  - State = S_WAIT, latched instr = 0.
  - All control outputs = 0, done = 0, err = 0, ready = 1 once in S_WAIT.
  - Reset mid-instruction aborts it: no write, no done.
- Back-to-back: start held high yields a new acceptance in the cycle after done, when the FSM is in S_WAIT again.

Optional Feature:
- Macro: ALU_SEQ_PERF_EN.
- Defined:
  - Adds output instr_count [15:0]: increments on each done, wraps 0xFFFF -> 0x0000.
  - Adds output err_count [7:0]: increments on each err, saturates at 0xFF.
  - Both counters reset to 0 on reset_n = 0.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum: S_WAIT, S_DEC, S_GETA, S_GETB, S_OPER, S_WRITE, S_WIMM
  - opcode constants: OPC_MOV = 110, OPC_ALU = 101
  - ALUop constants: ADD = 00, SUB = 01, AND = 10, NOTB = 11
  - vsel codes
- One sub-module, alu_seq_decode: combinational field extraction, legality check and sximm8 generation.

Test Plan:
- MOV imm: reset, then instr 0xD207 (MOV R2,#7) -> cycle 2: writenum = 2, vsel = 10, write = 1, sximm8 = 0x0007, done = 1.
- Negative immediate: instr 0xD1FF (MOV R1,#-1) -> sximm8 = 0xFFFF.
- ADD: instr 0xA161 (ADD R3,R1,R1) -> readnum sequence 1 (loada), then 1 (loadb); S_OPER alu_op = 00, loadc = 1; S_WRITE writenum = 3, write = 1; done at cycle 5.
- CMP: instr 0xA901 (CMP R1,R1) -> alu_op = 01, loads = 1, write never asserted, done at cycle 4.
- MOV reg: instr 0xC048 (MOV R2,R0 with sh = 01) -> GETB readnum = 0; OPER asel = 1, shift = 01, alu_op = 00; write at writenum = 2.
- Illegal and reset: instr 0xE000 -> err pulse in cycle 1, back to ready, no write. Separately, reset_n low during S_GETA -> all controls 0 immediately, ready = 1 after release, no done.
